// File: rtl/dac_ramp_pkg.sv
// dac_ramp_pkg: shared code width, midscale constant, channel states and slew helper
package dac_ramp_pkg;
    localparam int CODE_W = 16;
    localparam logic [CODE_W-1:0] MIDSCALE = 16'd32768;
    typedef enum logic [1:0] {IDLE, RAMP, SETTLE} chan_state_t;
    function automatic logic [CODE_W-1:0] step_toward(
        input logic [CODE_W-1:0] cur,
        input logic [CODE_W-1:0] tgt,
        input logic [CODE_W-1:0] step
    );
        logic [CODE_W:0] diff;
        diff = (tgt >= cur) ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
        return (step == '0 || diff <= {1'b0, step}) ? tgt : (tgt > cur) ? cur + step : cur - step;
    endfunction
endpackage

// File: rtl/dac_ramp_chan.sv
// dac_ramp_chan: one slew-limited DAC channel with ramp/settle FSM
module dac_ramp_chan
    import dac_ramp_pkg::*;
#(
    parameter int SETTLE_TICKS = 8,
    parameter logic [CODE_W-1:0] INIT_CODE = MIDSCALE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [CODE_W-1:0] step_i,
    output logic [CODE_W-1:0] data_o,
    output logic              busy_o,
    output logic              chg_o
);
    chan_state_t       state_q;
    logic [CODE_W-1:0] tgt_q, step_q, code_q, cnt_q, code_d;
    assign code_d = step_toward(code_q, tgt_q, step_q);
    assign data_o = code_q;
    assign busy_o = state_q != IDLE;
    assign chg_o  = tick_i && !abort_i && state_q == RAMP && code_d != code_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tgt_q   <= INIT_CODE;
            step_q  <= '0;
            code_q  <= INIT_CODE;
            cnt_q   <= '0;
        end else if (abort_i) begin
            tgt_q   <= code_q;
            state_q <= IDLE;
        end else begin
            if (tick_i && state_q == RAMP) begin
                code_q <= code_d;
                if (code_d == tgt_q) begin
                    cnt_q   <= CODE_W'(SETTLE_TICKS);
                    state_q <= (SETTLE_TICKS == 0) ? IDLE : SETTLE;
                end
            end
            if (tick_i && state_q == SETTLE) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q <= 16'd1) state_q <= IDLE;
            end
            // a load overrides the tick's state choice but the tick already used the old target
            if (load_i) begin
                tgt_q   <= code_i;
                step_q  <= step_i;
                state_q <= RAMP;
            end
        end
    end
endmodule

// File: rtl/dac_setpoint_ramp.sv
// dac_setpoint_ramp: dual-channel DAC setpoint slew limiter with tick timebase and load port
module dac_setpoint_ramp
    import dac_ramp_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SETTLE_TICKS = 8,
    parameter logic [CODE_W-1:0] INIT_CODE = MIDSCALE
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic              SET_VALID,
    output logic              SET_READY,
    input  logic              SET_CH,
    input  logic [CODE_W-1:0] SET_CODE,
    input  logic [CODE_W-1:0] SET_STEP,
    input  logic              ABORT,
    output logic [CODE_W-1:0] DATA_A,
    output logic [CODE_W-1:0] DATA_B,
    output logic              UPD,
    output logic              BUSY_A,
    output logic              BUSY_B
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, upd_q, tick, xfer, chg_a, chg_b;
    assign tick      = cnt_q == CW'(TICK_DIV - 1);
    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
    assign SET_READY = ready_q && !ABORT;
    assign xfer      = SET_VALID && SET_READY;
    assign UPD       = upd_q;
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
            upd_q   <= chg_a || chg_b;
        end
    end
    dac_ramp_chan #(.SETTLE_TICKS(SETTLE_TICKS), .INIT_CODE(INIT_CODE)) u_chan_a (
        .clk_i(SYS_CLK), .rst_ni(RST_N), .tick_i(tick), .load_i(xfer && !SET_CH),
        .abort_i(ABORT), .code_i(SET_CODE), .step_i(SET_STEP),
        .data_o(DATA_A), .busy_o(BUSY_A), .chg_o(chg_a)
    );
    dac_ramp_chan #(.SETTLE_TICKS(SETTLE_TICKS), .INIT_CODE(INIT_CODE)) u_chan_b (
        .clk_i(SYS_CLK), .rst_ni(RST_N), .tick_i(tick), .load_i(xfer && SET_CH),
        .abort_i(ABORT), .code_i(SET_CODE), .step_i(SET_STEP),
        .data_o(DATA_B), .busy_o(BUSY_B), .chg_o(chg_b)
    );
endmodule

// File: tb/tb_dac_setpoint_ramp.sv
// tb_dac_setpoint_ramp: directed self-checking bench for the setpoint ramp block
module tb_dac_setpoint_ramp;
    logic        SYS_CLK = 1'b0;
    logic        RST_N, SET_VALID, SET_READY, SET_CH, ABORT, UPD, BUSY_A, BUSY_B;
    logic [15:0] SET_CODE, SET_STEP, DATA_A, DATA_B;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 SYS_CLK = ~SYS_CLK;

    dac_setpoint_ramp #(.TICK_DIV(4), .SETTLE_TICKS(2)) dut (
        .SYS_CLK(SYS_CLK), .RST_N(RST_N), .SET_VALID(SET_VALID), .SET_READY(SET_READY),
        .SET_CH(SET_CH), .SET_CODE(SET_CODE), .SET_STEP(SET_STEP), .ABORT(ABORT),
        .DATA_A(DATA_A), .DATA_B(DATA_B), .UPD(UPD), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B)
    );

    task automatic do_reset();
        SET_VALID = 0; SET_CH = 0; SET_CODE = 0; SET_STEP = 0; ABORT = 0;
        RST_N = 0;
        repeat (2) @(negedge SYS_CLK);
        RST_N = 1;
        @(posedge SYS_CLK); #1;
    endtask

    task automatic load(input logic ch, input logic [15:0] code, input logic [15:0] step);
        SET_CH = ch; SET_CODE = code; SET_STEP = step; SET_VALID = 1; #1;
        n_cmp++; if (SET_READY !== 1'b1) begin n_err++; $display("FAIL load_ready got %b want 1", SET_READY); end
        @(posedge SYS_CLK); #1 SET_VALID = 0;
    endtask

    task automatic wait_upd(output int cyc);
        cyc = 0;
        do begin @(negedge SYS_CLK); cyc++; end while (UPD !== 1'b1 && cyc < 12);
        n_cmp++; if (UPD !== 1'b1) begin n_err++; $display("FAIL upd_timeout got %b want 1 after %0d cycles", UPD, cyc); end
    endtask

    task automatic test_reset();
        SET_VALID = 0; SET_CH = 0; SET_CODE = 0; SET_STEP = 0; ABORT = 0; RST_N = 0;
        repeat (2) @(negedge SYS_CLK);
        n_cmp++; if (DATA_A !== 16'd32768) begin n_err++; $display("FAIL rst_data_a got %0d want 32768", DATA_A); end
        n_cmp++; if (DATA_B !== 16'd32768) begin n_err++; $display("FAIL rst_data_b got %0d want 32768", DATA_B); end
        n_cmp++; if ({BUSY_A, BUSY_B} !== 2'b00) begin n_err++; $display("FAIL rst_busy got %b want 00", {BUSY_A, BUSY_B}); end
        n_cmp++; if (UPD !== 1'b0) begin n_err++; $display("FAIL rst_upd got %b want 0", UPD); end
        n_cmp++; if (SET_READY !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", SET_READY); end
        RST_N = 1; #1;
        n_cmp++; if (SET_READY !== 1'b0) begin n_err++; $display("FAIL rel_ready_early got %b want 0", SET_READY); end
        @(posedge SYS_CLK); #1;
        n_cmp++; if (SET_READY !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b want 1", SET_READY); end
    endtask

    task automatic test_ramp_up();
        int c;
        logic [15:0] exp_a [4] = '{16'd32793, 16'd32818, 16'd32843, 16'd32868};
        do_reset();
        load(1'b0, 16'd32868, 16'd25);
        for (int i = 0; i < 4; i++) begin
            wait_upd(c);
            n_cmp++; if (DATA_A !== exp_a[i]) begin n_err++; $display("FAIL ramp_a[%0d] got %0d want %0d", i, DATA_A, exp_a[i]); end
            if (i > 0) begin
                n_cmp++; if (c != 4) begin n_err++; $display("FAIL ramp_period[%0d] got %0d want 4", i, c); end
            end
            n_cmp++; if (BUSY_A !== 1'b1) begin n_err++; $display("FAIL ramp_busy_a[%0d] got %b want 1", i, BUSY_A); end
            n_cmp++; if (DATA_B !== 16'd32768 || BUSY_B !== 1'b0) begin n_err++; $display("FAIL ramp_b_idle[%0d] got %0d/%b want 32768/0", i, DATA_B, BUSY_B); end
        end
        repeat (7) @(negedge SYS_CLK);
        n_cmp++; if (BUSY_A !== 1'b1) begin n_err++; $display("FAIL settle_busy got %b want 1", BUSY_A); end
        @(negedge SYS_CLK);
        n_cmp++; if (BUSY_A !== 1'b0) begin n_err++; $display("FAIL settle_done got %b want 0", BUSY_A); end
        n_cmp++; if (DATA_A !== 16'd32868) begin n_err++; $display("FAIL settle_data got %0d want 32868", DATA_A); end
    endtask

    task automatic test_clamp();
        int c;
        do_reset();
        load(1'b0, 16'd0, 16'd30000);
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'd2768) begin n_err++; $display("FAIL clamp_a1 got %0d want 2768", DATA_A); end
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'd0) begin n_err++; $display("FAIL clamp_a2 got %0d want 0", DATA_A); end
        load(1'b1, 16'd65535, 16'd40000);
        wait_upd(c);
        n_cmp++; if (DATA_B !== 16'd65535) begin n_err++; $display("FAIL clamp_b got %0d want 65535", DATA_B); end
        n_cmp++; if (DATA_A !== 16'd0) begin n_err++; $display("FAIL clamp_a_hold got %0d want 0", DATA_A); end
        load(1'b1, 16'd1000, 16'd0);
        wait_upd(c);
        n_cmp++; if (DATA_B !== 16'd1000) begin n_err++; $display("FAIL jump_b got %0d want 1000", DATA_B); end
    endtask

    task automatic test_retarget();
        int c;
        int e;
        do_reset();
        load(1'b0, 16'd32868, 16'd25);
        wait_upd(c);
        wait_upd(c);
        load(1'b0, 16'd32768, 16'd10);
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'd32808) begin n_err++; $display("FAIL retgt_first got %0d want 32808", DATA_A); end
        do_reset();
        load(1'b0, 16'd32868, 16'd25);
        wait_upd(c);
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'd32818) begin n_err++; $display("FAIL retgt_start got %0d want 32818", DATA_A); end
        repeat (3) @(negedge SYS_CLK);
        load(1'b0, 16'd32768, 16'd10);
        e = 32843;
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'(e)) begin n_err++; $display("FAIL retgt_tick_old got %0d want %0d", DATA_A, e); end
        while (e != 32768) begin
            e = (e - 10 > 32768) ? e - 10 : 32768;
            wait_upd(c);
            n_cmp++; if (DATA_A !== 16'(e) || c != 4) begin n_err++; $display("FAIL retgt_down got %0d/%0d want %0d/4", DATA_A, c, e); end
        end
        repeat (10) @(negedge SYS_CLK);
        n_cmp++; if (DATA_A !== 16'd32768 || BUSY_A !== 1'b0) begin n_err++; $display("FAIL retgt_final got %0d/%b want 32768/0", DATA_A, BUSY_A); end
    endtask

    task automatic test_abort();
        int c;
        bit seen;
        do_reset();
        load(1'b1, 16'd1000, 16'd1000);
        wait_upd(c);
        n_cmp++; if (DATA_B !== 16'd31768) begin n_err++; $display("FAIL abort_pre_b got %0d want 31768", DATA_B); end
        load(1'b0, 16'd32868, 16'd25);
        wait_upd(c);
        n_cmp++; if (DATA_A !== 16'd32793 || DATA_B !== 16'd30768) begin n_err++; $display("FAIL abort_pre got %0d/%0d want 32793/30768", DATA_A, DATA_B); end
        ABORT = 1; SET_VALID = 1; SET_CH = 0; SET_CODE = 16'd0; SET_STEP = 16'd0; #1;
        n_cmp++; if (SET_READY !== 1'b0) begin n_err++; $display("FAIL abort_ready got %b want 0", SET_READY); end
        @(posedge SYS_CLK); #1 ABORT = 0; SET_VALID = 0;
        @(negedge SYS_CLK);
        n_cmp++; if ({BUSY_A, BUSY_B} !== 2'b00) begin n_err++; $display("FAIL abort_busy got %b want 00", {BUSY_A, BUSY_B}); end
        seen = 0;
        repeat (12) begin @(negedge SYS_CLK); if (UPD !== 1'b0) seen = 1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL abort_upd got 1 want 0"); end
        n_cmp++; if (DATA_A !== 16'd32793 || DATA_B !== 16'd30768) begin n_err++; $display("FAIL abort_frozen got %0d/%0d want 32793/30768", DATA_A, DATA_B); end
        n_cmp++; if (SET_READY !== 1'b1) begin n_err++; $display("FAIL abort_ready_back got %b want 1", SET_READY); end
    endtask

    task automatic test_async_reset();
        int c;
        do_reset();
        load(1'b0, 16'd32868, 16'd25);
        wait_upd(c);
        @(posedge SYS_CLK); #2 RST_N = 0; #1;
        n_cmp++; if (DATA_A !== 16'd32768 || DATA_B !== 16'd32768) begin n_err++; $display("FAIL arst_data got %0d/%0d want 32768/32768", DATA_A, DATA_B); end
        n_cmp++; if ({BUSY_A, BUSY_B, SET_READY, UPD} !== 4'b0000) begin n_err++; $display("FAIL arst_flags got %b want 0000", {BUSY_A, BUSY_B, SET_READY, UPD}); end
        @(negedge SYS_CLK); RST_N = 1;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_retarget();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dac_setpoint_ramp.md
Name: dac_setpoint_ramp

Overview:
Dual-channel setpoint slew limiter that sits directly upstream of the DAC8563 driver and produces its DATA_A/DATA_B codes. Host logic loads a target code plus a per-channel step size through a valid/ready port. Each channel then moves its output toward the target by at most one step per update tick, and reports BUSY until the ramp and a settle interval complete. This prevents step changes on the MFC setpoint lines and gives the controller a clear done indication.

Parameters:
TICK_DIV, 50000, SYS_CLK cycles per update tick (1 kHz at 50 MHz); legal range >= 2
SETTLE_TICKS, 8, ticks BUSY stays high after the output reaches target; 0 = none
INIT_CODE, 16'd32768, reset/midscale code (0 V on the ±10 V output)

Ports:
SYS_CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SET_VALID  in  1  setpoint load request
SET_READY  out  1  block accepts a load; transfer on SET_VALID & SET_READY
SET_CH  in  1  0 = channel A, 1 = channel B
SET_CODE  in  16  target DAC code
SET_STEP  in  16  max code change per tick; 0 = jump to target on next tick
ABORT  in  1  freeze both channels at their current codes
DATA_A  out  16  channel A code to DAC driver
DATA_B  out  16  channel B code to DAC driver
UPD  out  1  one-cycle pulse when DATA_A or DATA_B changed
BUSY_A  out  1  channel A ramping or settling
BUSY_B  out  1  channel B ramping or settling

Behaviour:
- Clock and reset: SYS_CLK is the only clock. RST_N is asynchronous and active-low.
- Reset values: DATA_A = DATA_B = INIT_CODE; targets = INIT_CODE; steps = 0; tick counter = 0; UPD = 0; BUSY_x = 0; SET_READY = 0.
- SET_READY is registered. It goes to 1 on the first SYS_CLK edge after RST_N deasserts, and is combinationally 0 whenever ABORT = 1.
- Tick: a free-running counter runs 0..TICK_DIV-1. The internal tick is high in the cycle where count == TICK_DIV-1, then the counter wraps to 0.
- Load: on a transfer, the selected channel latches target = SET_CODE and step = SET_STEP, then enters RAMP. The other channel is unaffected.
- Retargeting: a load to a channel that is already in RAMP or SETTLE retargets it from its current code, with no glitch or reset of the code.
- Load in a tick cycle: the tick evaluates with the old target and step. The new values take effect from the next tick.
- Per-channel FSM states are IDLE, RAMP and SETTLE. BUSY_x = (state != IDLE), registered.
- RAMP, on each tick, using 17-bit arithmetic:
  - diff = |tgt - cur|.
  - If step == 0 or diff <= step: cur = tgt.
  - Otherwise cur = cur ± step, toward the target.
  - The result never wraps and never overshoots the target.
  - When cur == tgt after the update (or already equal at the tick), load settle counter = SETTLE_TICKS and go to SETTLE. If SETTLE_TICKS == 0, go to IDLE instead.
- SETTLE: decrement the settle counter on each tick. When it reaches 0, go to IDLE. A new load returns the channel to RAMP.
- Output timing: DATA_x and UPD are registered and update on the clock edge that ends the tick cycle. UPD = 1 for exactly one cycle if either code changed, otherwise 0.
- ABORT (level-sensitive, priority over SET), for each channel:
  - target = current code; state goes to IDLE on the next edge.
  - No code change and no UPD.
  - Any SET_VALID in that cycle is not accepted.
- RST_N asserted mid-ramp: all state returns to reset values immediately (asynchronously). DATA_x = INIT_CODE.

Decomposition:
- Package dac_ramp_pkg:
  - CODE_W = 16;
  - MIDSCALE = 16'd32768;
  - chan_state_t enum {IDLE, RAMP, SETTLE};
  - a helper function step_toward(cur, tgt, step) that returns the clamped next code.
- Sub-module dac_ramp_chan, instantiated twice (A, B). It holds target, step, code, state and settle counter.
- Top level owns the tick counter, SET_READY, SET_CH decode, ABORT fan-out and the UPD OR-combine.

Test Plan:
All scenarios use TICK_DIV = 4 and SETTLE_TICKS = 2.
1. Reset: hold RST_N = 0 -> DATA_A = DATA_B = 32768, BUSY = 0, UPD = 0, SET_READY = 0. Release RST_N -> SET_READY = 1 after one edge.
2. Upward ramp: load A with CODE = 32868, STEP = 25 ->
   - DATA_A = 32793, 32818, 32843, 32868 on consecutive ticks, with one UPD pulse per tick.
   - BUSY_A = 1 throughout, falling 2 ticks after 32868 is reached.
   - DATA_B and BUSY_B unchanged.
3. Clamping:
   - Load A with 0, STEP = 30000 -> DATA_A = 2768, then 0 (no wrap).
   - Load B with 65535, STEP = 40000 -> DATA_B = 65535 in one tick.
   - Load B with 1000, STEP = 0 -> jump to 1000 on the next tick.
4. Retarget mid-ramp: A at 32818 heading to 32868 (STEP = 25); load A with 32768, STEP = 10 -> next ticks 32808, 32798, ... down to 32768, no overshoot. Load issued in a tick cycle -> that tick still uses the old target.
5. Abort: ABORT for 1 cycle mid-ramp with SET_VALID high ->
   - SET_READY = 0 and the load is not accepted.
   - Codes frozen, BUSY_A = BUSY_B = 0 next cycle, no UPD on subsequent ticks.
6. Reset mid-ramp: assert RST_N asynchronously (between edges) during a ramp -> DATA_x = 32768 and BUSY = 0 immediately, with no clock edge needed.
